// File: rtl/npc_if.sv
`default_nettype none
// =============================================================================
// Module   : npc_if
// Purpose  : Fetch-side and EX-feedback signal bundle of the next-PC predictor.
// Revision : 1.0 - initial release
// =============================================================================
interface npc_if #(
    parameter int CNT_W = 32
);
    logic [31:0]      pc;
    logic             stall;
    logic [31:0]      npc;
    logic             if_pred_taken;
    logic [31:0]      if_pred_target;
    logic             ex_valid;
    logic [31:0]      ex_pc;
    logic             ex_taken;
    logic [31:0]      ex_target;
    logic             ex_pred_taken;
    logic [31:0]      ex_pred_target;
    logic             flush;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] mispred_cnt;

    modport master (
        output pc, stall, ex_valid, ex_pc, ex_taken, ex_target,
               ex_pred_taken, ex_pred_target,
        input  npc, if_pred_taken, if_pred_target, flush,
               branch_cnt, mispred_cnt
    );

    modport slave (
        input  pc, stall, ex_valid, ex_pc, ex_taken, ex_target,
               ex_pred_taken, ex_pred_target,
        output npc, if_pred_taken, if_pred_target, flush,
               branch_cnt, mispred_cnt
    );
endinterface
`default_nettype wire

// File: rtl/npc_predictor.sv
`default_nettype none
// =============================================================================
// Module   : npc_predictor
// Purpose  : Next-PC generator with a direct-mapped BTB, mispredict redirect,
//            stall-safe pending redirect and branch statistics.
// Revision : 1.0 - initial release
// =============================================================================
module npc_predictor #(
    parameter int IDX_W = 4,
    parameter int CNT_W = 32
) (
    input  logic clk,
    input  logic rst,
    npc_if.slave bus
);
    localparam int C_ENTRIES = 2 ** IDX_W;
    localparam int C_TAG_W   = 30 - IDX_W;

    logic [C_ENTRIES-1:0]              valid_q, valid_d;
    logic [C_ENTRIES-1:0][C_TAG_W-1:0] tag_q,   tag_d;
    logic [C_ENTRIES-1:0][31:0]        tgt_q,   tgt_d;
    logic [C_ENTRIES-1:0][1:0]         ctr_q,   ctr_d;
    logic                              pend_v_q, pend_v_d;
    logic [31:0]                       pend_tgt_q, pend_tgt_d;
    logic [CNT_W-1:0]                  branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0]                  mispred_cnt_q, mispred_cnt_d;

    logic [IDX_W-1:0]   w_f_idx, w_e_idx;
    logic [C_TAG_W-1:0] w_f_tag, w_e_tag;
    logic               w_f_hit, w_e_hit, w_pred_taken, w_redirect;
    logic [31:0]        w_pc_plus4, w_pred_target, w_correct_pc;

    // Fetch-side lookup reads the registered table, so a same-cycle update
    // of the same index is only visible from the next cycle on.
    always_comb begin
        w_f_idx       = bus.pc[IDX_W+1:2];
        w_f_tag       = bus.pc[31:IDX_W+2];
        w_f_hit       = valid_q[w_f_idx] && (tag_q[w_f_idx] == w_f_tag);
        w_pred_taken  = w_f_hit && ctr_q[w_f_idx][1];
        w_pc_plus4    = bus.pc + 32'd4;
        w_pred_target = w_pred_taken ? tgt_q[w_f_idx] : w_pc_plus4;
    end

    always_comb begin
        w_redirect   = bus.ex_valid &&
                       ((bus.ex_taken != bus.ex_pred_taken) ||
                        (bus.ex_taken && (bus.ex_target != bus.ex_pred_target)));
        w_correct_pc = bus.ex_taken ? bus.ex_target : (bus.ex_pc + 32'd4);
    end

    assign bus.npc            = w_redirect ? w_correct_pc :
                                pend_v_q   ? pend_tgt_q   : w_pred_target;
    assign bus.if_pred_taken  = w_pred_taken;
    assign bus.if_pred_target = w_pred_target;
    assign bus.flush          = w_redirect;
    assign bus.branch_cnt     = branch_cnt_q;
    assign bus.mispred_cnt    = mispred_cnt_q;

    // The PC register ignores npc while stalled, so a redirect seen during a
    // stall is parked here and replayed on the first unstalled cycle.
    always_comb begin
        pend_v_d   = pend_v_q;
        pend_tgt_d = pend_tgt_q;
        if (w_redirect && bus.stall) begin
            pend_v_d   = 1'b1;
            pend_tgt_d = w_correct_pc;
        end else if (!bus.stall) begin
            pend_v_d   = 1'b0;
        end
    end

    always_comb begin
        w_e_idx = bus.ex_pc[IDX_W+1:2];
        w_e_tag = bus.ex_pc[31:IDX_W+2];
        w_e_hit = valid_q[w_e_idx] && (tag_q[w_e_idx] == w_e_tag);
        valid_d = valid_q;
        tag_d   = tag_q;
        tgt_d   = tgt_q;
        ctr_d   = ctr_q;
        if (bus.ex_valid) begin
            if (w_e_hit) begin
                if (bus.ex_taken) begin
                    tgt_d[w_e_idx] = bus.ex_target;
                    if (ctr_q[w_e_idx] != 2'b11) ctr_d[w_e_idx] = ctr_q[w_e_idx] + 2'd1;
                end else if (ctr_q[w_e_idx] != 2'b00) begin
                    ctr_d[w_e_idx] = ctr_q[w_e_idx] - 2'd1;
                end
            end else if (bus.ex_taken) begin
                valid_d[w_e_idx] = 1'b1;
                tag_d[w_e_idx]   = w_e_tag;
                tgt_d[w_e_idx]   = bus.ex_target;
                ctr_d[w_e_idx]   = 2'b10;
            end
        end
    end

    always_comb begin
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (bus.ex_valid && (branch_cnt_q != '1)) branch_cnt_d  = branch_cnt_q + CNT_W'(1);
        if (w_redirect && (mispred_cnt_q != '1))  mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q       <= '0;
            tag_q         <= '0;
            tgt_q         <= '0;
            ctr_q         <= {C_ENTRIES{2'b01}};
            pend_v_q      <= 1'b0;
            pend_tgt_q    <= '0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            valid_q       <= valid_d;
            tag_q         <= tag_d;
            tgt_q         <= tgt_d;
            ctr_q         <= ctr_d;
            pend_v_q      <= pend_v_d;
            pend_tgt_q    <= pend_tgt_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_npc_predictor.sv
`default_nettype none
// =============================================================================
// Module   : tb_npc_predictor
// Purpose  : Directed scoreboard bench for npc_predictor.
// Revision : 1.0 - initial release
// =============================================================================
module tb_npc_predictor;
    localparam int SEL_NPC = 0, SEL_PT = 1, SEL_PTGT = 2, SEL_FLUSH = 3,
                   SEL_BR = 4, SEL_MIS = 5;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    exp_t sb[$];

    npc_if #(.CNT_W(32)) bus ();

    npc_predictor #(.IDX_W(4), .CNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic want(input string n, input int s, input logic [31:0] e);
        sb.push_back('{n, s, e});
    endtask

    function automatic logic [31:0] observe(input int s);
        case (s)
            SEL_NPC:   return bus.npc;
            SEL_PT:    return {31'd0, bus.if_pred_taken};
            SEL_PTGT:  return bus.if_pred_target;
            SEL_FLUSH: return {31'd0, bus.flush};
            SEL_BR:    return bus.branch_cnt;
            default:   return bus.mispred_cnt;
        endcase
    endfunction

    task automatic check_all();
        while (sb.size() > 0) begin
            exp_t        e;
            logic [31:0] o;
            e = sb.pop_front();
            o = observe(e.sel);
            checks++;
            assert (o === e.exp) else begin
                failures++;
                $error("FAIL %s observed=%h expected=%h", e.name, o, e.exp);
            end
        end
    endtask

    task automatic at_cycle(input logic [31:0] p, input logic s);
        @(negedge clk);
        bus.pc       = p;
        bus.stall    = s;
        bus.ex_valid = 1'b0;
    endtask

    task automatic resolve(input logic [31:0] epc, input logic tk, input logic [31:0] tgt,
                           input logic ptk, input logic [31:0] ptgt);
        bus.ex_valid       = 1'b1;
        bus.ex_pc          = epc;
        bus.ex_taken       = tk;
        bus.ex_target      = tgt;
        bus.ex_pred_taken  = ptk;
        bus.ex_pred_target = ptgt;
    endtask

    task automatic settle();
        #2;
        check_all();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        bus.pc = '0; bus.stall = 1'b0; bus.ex_valid = 1'b0; bus.ex_pc = '0;
        bus.ex_taken = 1'b0; bus.ex_target = '0; bus.ex_pred_taken = 1'b0;
        bus.ex_pred_target = '0;

        // Reset state and pc+4 wrap
        at_cycle(32'h100, 1'b0);
        want("rst_npc", SEL_NPC, 32'h104); want("rst_pt", SEL_PT, 0);
        want("rst_flush", SEL_FLUSH, 0); want("rst_br", SEL_BR, 0); want("rst_mis", SEL_MIS, 0);
        settle();
        at_cycle(32'hFFFF_FFFC, 1'b0);
        want("wrap_npc", SEL_NPC, 32'h0); want("wrap_ptgt", SEL_PTGT, 32'h0);
        settle();
        rst = 1'b0;

        // First mispredict allocates 0x100 -> 0x200
        at_cycle(32'h500, 1'b0); resolve(32'h100, 1, 32'h200, 0, 32'h104);
        want("alloc_flush", SEL_FLUSH, 1); want("alloc_npc", SEL_NPC, 32'h200);
        settle();
        at_cycle(32'h100, 1'b0);
        want("alloc_pt", SEL_PT, 1); want("alloc_pnpc", SEL_NPC, 32'h200);
        want("alloc_flush0", SEL_FLUSH, 0); want("alloc_mis", SEL_MIS, 1); want("alloc_br", SEL_BR, 1);
        settle();

        // Counter walk: 10 -> 11 -> 11 -> 10 -> 01 -> 00 -> 00 -> 01
        repeat (2) begin
            at_cycle(32'h100, 1'b0); resolve(32'h100, 1, 32'h200, 1, 32'h200);
            want("up_flush", SEL_FLUSH, 0); want("up_npc", SEL_NPC, 32'h200);
            settle();
        end
        at_cycle(32'h100, 1'b0); resolve(32'h100, 0, 32'h0, 1, 32'h200);
        want("nt1_pt", SEL_PT, 1); want("nt1_ptgt", SEL_PTGT, 32'h200);
        want("nt1_flush", SEL_FLUSH, 1); want("nt1_npc", SEL_NPC, 32'h104);
        settle();
        at_cycle(32'h100, 1'b0); resolve(32'h100, 0, 32'h0, 1, 32'h200);
        want("nt2_pt", SEL_PT, 1); want("nt2_flush", SEL_FLUSH, 1);
        settle();
        repeat (2) begin
            at_cycle(32'h100, 1'b0); resolve(32'h100, 0, 32'h0, 0, 32'h104);
            want("nt_low_pt", SEL_PT, 0); want("nt_low_flush", SEL_FLUSH, 0);
            want("nt_low_npc", SEL_NPC, 32'h104);
            settle();
        end
        at_cycle(32'h100, 1'b0); resolve(32'h100, 1, 32'h200, 0, 32'h104);
        want("rt_flush", SEL_FLUSH, 1); want("rt_npc", SEL_NPC, 32'h200);
        settle();
        at_cycle(32'h100, 1'b0);
        want("sat0_pt", SEL_PT, 0); want("sat0_npc", SEL_NPC, 32'h104);
        want("sat0_br", SEL_BR, 8); want("sat0_mis", SEL_MIS, 4);
        settle();

        // Redirect under a three-cycle stall
        at_cycle(32'h500, 1'b1); resolve(32'h408, 1, 32'h300, 0, 32'h40C);
        want("stl_flush", SEL_FLUSH, 1); want("stl_npc", SEL_NPC, 32'h300);
        settle();
        repeat (2) begin
            at_cycle(32'h500, 1'b1);
            want("stl_hold_npc", SEL_NPC, 32'h300); want("stl_hold_flush", SEL_FLUSH, 0);
            settle();
        end
        at_cycle(32'h500, 1'b0);
        want("stl_release_npc", SEL_NPC, 32'h300);
        settle();
        at_cycle(32'h500, 1'b0);
        want("stl_clear_npc", SEL_NPC, 32'h504);
        settle();

        // Taken-with-wrong-target mispredict retargets the entry
        at_cycle(32'h500, 1'b0); resolve(32'h408, 1, 32'h320, 1, 32'h300);
        want("tgt_flush", SEL_FLUSH, 1); want("tgt_npc", SEL_NPC, 32'h320);
        settle();
        at_cycle(32'h408, 1'b0);
        want("tgt_pt", SEL_PT, 1); want("tgt_ptgt", SEL_PTGT, 32'h320);
        want("tgt_br", SEL_BR, 10); want("tgt_mis", SEL_MIS, 6);
        settle();

        // Alias eviction with same-cycle lookup of the old entry
        at_cycle(32'h300, 1'b0); resolve(32'h100, 1, 32'h200, 0, 32'h104);
        want("prime_npc", SEL_NPC, 32'h200);
        settle();
        at_cycle(32'h100, 1'b0); resolve(32'h140, 1, 32'h600, 0, 32'h144);
        want("war_pt", SEL_PT, 1); want("war_ptgt", SEL_PTGT, 32'h200);
        want("war_npc", SEL_NPC, 32'h600); want("war_flush", SEL_FLUSH, 1);
        settle();
        at_cycle(32'h100, 1'b0);
        want("evict_pt", SEL_PT, 0); want("evict_npc", SEL_NPC, 32'h104);
        settle();
        at_cycle(32'h140, 1'b0);
        want("alias_pt", SEL_PT, 1); want("alias_npc", SEL_NPC, 32'h600);
        want("alias_br", SEL_BR, 12); want("alias_mis", SEL_MIS, 8);
        settle();

        // Asynchronous reset while a redirect is pending
        at_cycle(32'h500, 1'b1); resolve(32'h408, 1, 32'h700, 1, 32'h320);
        want("pre_flush", SEL_FLUSH, 1);
        settle();
        at_cycle(32'h140, 1'b1);
        want("pre_pend_npc", SEL_NPC, 32'h700); want("pre_pt", SEL_PT, 1);
        want("pre_br", SEL_BR, 13);
        settle();
        rst = 1'b1;
        want("arst_pt", SEL_PT, 0); want("arst_ptgt", SEL_PTGT, 32'h144);
        want("arst_npc", SEL_NPC, 32'h144); want("arst_br", SEL_BR, 0);
        want("arst_mis", SEL_MIS, 0);
        #1;
        check_all();
        at_cycle(32'h408, 1'b1);
        want("inrst_pt", SEL_PT, 0); want("inrst_npc", SEL_NPC, 32'h40C);
        settle();
        rst = 1'b0;
        at_cycle(32'h500, 1'b1);
        want("post_npc", SEL_NPC, 32'h504); want("post_flush", SEL_FLUSH, 0);
        settle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
